// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and Avalon-MM register/IRQ interface
module keypad_scanner #(
  parameter int SCAN_DIV     = 5000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic        key_active,
  output logic        irq
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_DONE  = DB_W'(DEBOUNCE_CNT);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  logic [3:0]       row_s1_q, row_s1_d;
  logic [3:0]       row_s2_q, row_s2_d;
  logic [DIV_W-1:0] div_q, div_d;
  state_t           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       col_n_q, col_n_d;
  logic [1:0]       cand_q, cand_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_active_q, key_active_d;
  logic             irqmask_q, irqmask_d;
  logic             edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             tick;
  logic             any_low;
  logic [1:0]       low_idx;
  logic [DB_W-1:0]  db_inc;
  logic             capture;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata[31:1];

  // Two-flop synchronizer: rows come straight from the keypad, unrelated to clk.
  always_comb begin
    row_s1_d = row_n;
    row_s2_d = row_s1_q;
  end

  // Column dwell counter; the tick is the only instant rows are evaluated.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  // Lowest-index low row wins when several rows are down together.
  always_comb begin
    any_low = 1'b0;
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s2_q[i]) begin
        any_low = 1'b1;
        low_idx = 2'(i);
      end
    end
  end

  // Scan/debounce state machine; the column only moves while nothing is pending.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    cand_d       = cand_q;
    db_cnt_d     = db_cnt_q;
    key_code_d   = key_code_q;
    key_active_d = key_active_q;
    capture      = 1'b0;
    db_inc       = db_cnt_q + DB_W'(1);

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (any_low) begin
            cand_d   = low_idx;
            db_cnt_d = DB_ONE;
            if (DB_ONE == DB_DONE) begin
              state_d      = HELD;
              key_code_d   = {low_idx, col_q};
              key_active_d = 1'b1;
              capture      = 1'b1;
            end else begin
              state_d = PRESS_DB;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        PRESS_DB: begin
          if (any_low && (low_idx == cand_q)) begin
            db_cnt_d = db_inc;
            if (db_inc == DB_DONE) begin
              state_d      = HELD;
              key_code_d   = {cand_q, col_q};
              key_active_d = 1'b1;
              capture      = 1'b1;
            end
          end else begin
            state_d = SCAN;
            col_d   = col_q + 2'd1;
          end
        end
        HELD: begin
          // Any key still down keeps the original code; only a full release counts.
          if (!any_low) begin
            db_cnt_d = DB_ONE;
            if (DB_ONE == DB_DONE) begin
              state_d      = SCAN;
              key_active_d = 1'b0;
            end else begin
              state_d = REL_DB;
            end
          end
        end
        REL_DB: begin
          if (!any_low) begin
            db_cnt_d = db_inc;
            if (db_inc == DB_DONE) begin
              state_d      = SCAN;
              key_active_d = 1'b0;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: begin
          state_d = SCAN;
        end
      endcase
    end

    col_n_d = ~(4'b0001 << col_d);
  end

  // Register file: capture beats a same-cycle clearing write.
  always_comb begin
    wr_en     = chipselect & ~write_n;
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_en && (address == 2'd2)) begin
      irqmask_d = writedata[0];
    end
    if (capture) begin
      edgecap_d = 1'b1;
    end else if (wr_en && (address == 2'd3)) begin
      edgecap_d = 1'b0;
    end
    case (address)
      2'd0:    readdata_d = {27'b0, key_active_q, key_code_q};
      2'd2:    readdata_d = {31'b0, irqmask_q};
      2'd3:    readdata_d = {31'b0, edgecap_q};
      default: readdata_d = 32'b0;
    endcase
  end

  // All state flops, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_s1_q     <= 4'b1111;
      row_s2_q     <= 4'b1111;
      div_q        <= '0;
      state_q      <= SCAN;
      col_q        <= 2'd0;
      col_n_q      <= 4'b1110;
      cand_q       <= 2'd0;
      db_cnt_q     <= '0;
      key_code_q   <= 4'd0;
      key_active_q <= 1'b0;
      irqmask_q    <= 1'b0;
      edgecap_q    <= 1'b0;
      readdata_q   <= 32'b0;
    end else begin
      row_s1_q     <= row_s1_d;
      row_s2_q     <= row_s2_d;
      div_q        <= div_d;
      state_q      <= state_d;
      col_q        <= col_d;
      col_n_q      <= col_n_d;
      cand_q       <= cand_d;
      db_cnt_q     <= db_cnt_d;
      key_code_q   <= key_code_d;
      key_active_q <= key_active_d;
      irqmask_q    <= irqmask_d;
      edgecap_q    <= edgecap_d;
      readdata_q   <= readdata_d;
    end
  end

  assign readdata   = readdata_q;
  assign col_n      = col_n_q;
  assign key_active = key_active_q;
  assign irq        = edgecap_q & irqmask_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - keypad_scanner bench: behavioural model, directed scenarios, random traffic
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_active;
  logic        irq;

  int errors = 0;
  int checks = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .row_n      (row_n),
    .col_n      (col_n),
    .key_active (key_active),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Model: rows delayed two clocks, evaluated every SD clocks; a key is accepted after
  // DB consecutive ticks with the same lowest low row, released after DB all-high ticks.
  logic [3:0]  m_s1, m_s2;
  int          m_div, m_col, m_cand, m_streak, m_rel, m_low;
  bit          m_pressing, m_held, m_active, m_mask, m_ec, m_tick, m_cap, m_wr;
  logic [3:0]  m_code;
  logic [31:0] m_rd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_div = 0; m_col = 0; m_cand = 0; m_streak = 0; m_rel = 0;
      m_pressing = 0; m_held = 0; m_active = 0; m_mask = 0; m_ec = 0; m_code = 0; m_rd = 0;
    end else begin
      case (address)
        2'd0:    m_rd = {27'b0, m_active, m_code};
        2'd2:    m_rd = {31'b0, m_mask};
        2'd3:    m_rd = {31'b0, m_ec};
        default: m_rd = 32'b0;
      endcase
      m_wr   = chipselect && !write_n;
      m_cap  = 0;
      m_tick = (m_div == SD - 1);
      m_div  = m_tick ? 0 : m_div + 1;
      if (m_tick) begin
        m_low = -1;
        for (int i = 3; i >= 0; i--) if (!m_s2[i]) m_low = i;
        if (!m_held) begin
          if (!m_pressing) begin
            if (m_low >= 0) begin m_pressing = 1; m_cand = m_low; m_streak = 1; end
            else m_col = (m_col + 1) % 4;
          end else if (m_low == m_cand) begin
            m_streak++;
          end else begin
            m_pressing = 0; m_col = (m_col + 1) % 4;
          end
          if (m_pressing && m_streak >= DB) begin
            m_held = 1; m_rel = 0; m_active = 1; m_cap = 1;
            m_code = 4'(m_cand * 4 + m_col);
          end
        end else begin
          if (m_low < 0) m_rel++; else m_rel = 0;
          if (m_rel >= DB) begin m_held = 0; m_pressing = 0; m_active = 0; end
        end
      end
      if (m_cap) m_ec = 1;
      else if (m_wr && address == 2'd3) m_ec = 0;
      if (m_wr && address == 2'd2) m_mask = writedata[0];
      m_s2 = m_s1;
      m_s1 = row_n;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  logic [3:0] exp_col;
  always @(negedge clk) begin
    exp_col = 4'hF;
    exp_col[m_col] = 1'b0;
    chk("col_n", 32'(col_n), 32'(exp_col));
    chk("key_active", 32'(key_active), 32'(m_active));
    chk("irq", 32'(irq), 32'(m_ec & m_mask));
    chk("readdata", readdata, m_rd);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Move to just after a tick edge (optionally in a given column).
  task automatic align(input int col);
    int n = 0;
    do begin step(); n++; end while (!(m_div == 0 && (col < 0 || m_col == col)) && n < 64);
    if (!(m_div == 0 && (col < 0 || m_col == col))) begin
      checks++; errors++;
      $display("FAIL align_timeout: column %0d not reached within 64 cycles", col);
    end
  endtask

  // Hold a row pattern so that exactly n ticks observe it.
  task automatic drive_for(input logic [3:0] p, input int n);
    row_n = p;
    repeat (4 * n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  logic [3:0] e;

  initial begin
    reset_n = 1'b0; row_n = 4'hF; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'b0;
    repeat (3) step();
    chk("rst_col_n", 32'(col_n), 32'h0000000E);
    chk("rst_key_active", 32'(key_active), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    reset_n = 1'b1;

    // Idle scanning rotates the one-cold column every SD clocks.
    align(0);
    e = 4'hE;
    for (int k = 0; k < 5; k++) begin
      chk("idle_col", 32'(col_n), 32'(e));
      step();
      chk("idle_col_hold", 32'(col_n), 32'(e));
      repeat (3) step();
      e = {e[2:0], e[3]};
    end
    chk("idle_key_active", 32'(key_active), 32'h0);
    chk("idle_irq", 32'(irq), 32'h0);

    // Row 2 pressed during column 1 -> code 9.
    align(1);
    drive_for(4'b1011, 3);
    chk("press_active", 32'(key_active), 32'h1);
    chk("press_col_frozen", 32'(col_n), 32'hD);
    address = 2'd0;
    drive_for(4'b1011, 1);
    chk("press_data", readdata, 32'h19);
    address = 2'd3;
    drive_for(4'b1011, 1);
    chk("press_edgecap", readdata, 32'h1);
    chk("press_col_still", 32'(col_n), 32'hD);

    // Release with a one-tick bounce: back to held, no second capture.
    wr(2'd3, 32'h0);
    align(-1);
    drive_for(4'hF, 1);
    drive_for(4'b1011, 1);
    chk("bounce_active", 32'(key_active), 32'h1);
    address = 2'd3;
    drive_for(4'b1011, 1);
    chk("bounce_no_cap", readdata, 32'h0);
    address = 2'd0;
    drive_for(4'hF, 3);
    chk("release_active", 32'(key_active), 32'h0);
    drive_for(4'hF, 1);
    chk("release_code", readdata, 32'h09);

    // A two-tick glitch is rejected.
    align(-1);
    drive_for(4'b1110, 2);
    drive_for(4'hF, 2);
    chk("glitch_active", 32'(key_active), 32'h0);
    address = 2'd3;
    drive_for(4'hF, 1);
    chk("glitch_edgecap", readdata, 32'h0);

    // Interrupt: clearing write on the capture cycle loses to the capture.
    wr(2'd2, 32'h1);
    align(-1);
    drive_for(4'b1101, 2);
    repeat (3) step();
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3;
    step();
    chipselect = 1'b0; write_n = 1'b1;
    chk("irq_after_race", 32'(irq), 32'h1);
    chk("irq_active", 32'(key_active), 32'h1);
    wr(2'd3, 32'h0);
    chk("irq_cleared", 32'(irq), 32'h0);
    align(-1);
    drive_for(4'hF, 3);

    // Rows 0 and 3 on column 2 -> row 0 wins, code 2; then reset in HELD.
    align(2);
    drive_for(4'b0110, 3);
    chk("multi_active", 32'(key_active), 32'h1);
    address = 2'd0;
    drive_for(4'b0110, 1);
    chk("multi_data", readdata, 32'h12);
    reset_n = 1'b0;
    #1;
    chk("held_rst_col_n", 32'(col_n), 32'hE);
    chk("held_rst_active", 32'(key_active), 32'h0);
    chk("held_rst_irq", 32'(irq), 32'h0);
    chk("held_rst_readdata", readdata, 32'h0);
    step(); step();
    row_n = 4'hF;
    reset_n = 1'b1;
    step();
    chk("post_rst_col_n", 32'(col_n), 32'hE);

    // Random traffic checked cycle by cycle against the model.
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 2) == 0) row_n = 4'hF;
      else row_n = 4'($urandom);
      for (int c = 0; c < int'($urandom_range(1, 14)); c++) begin
        address = 2'($urandom);
        if ($urandom_range(0, 9) == 0) begin
          chipselect = 1'($urandom); write_n = 1'b0; writedata = $urandom;
        end else begin
          chipselect = 1'($urandom); write_n = 1'b1;
        end
        if ($urandom_range(0, 399) == 0) reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
